mem_port_arbiter: RTL and testbench

- Shares one external memory port (MREQ/WRITE/SIZE/address/data, active-low ACK) between the instruction-fetch requester and the data-access requester.
- Each requester sees a simple req/ack handshake. The arbiter sequences one bus transaction at a time, captures read data, and applies bounded data-first priority.
- Sits between the core (IF and MEM stages) and the memory/bus interface in top.

---
 rtl/mem_port_arbiter_pkg.sv | 9 +
 rtl/mem_port_arbiter_grant_sel.sv | 16 +
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared encodings for the fetch/data memory port arbiter
package mem_port_arbiter_pkg;
   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;
   localparam logic [31:0] STDOUT_ADDR = 32'hF000_0000;
   localparam logic [31:0] EXIT_ADDR   = 32'hF000_0004;
endpackage

// File: rtl/mem_port_arbiter_grant_sel.sv
// arb_grant_sel: combinational grant choice with bounded data-first priority
module arb_grant_sel #(
   parameter int MAX_DSTREAK = 4,
   parameter int SW = 3
) (
   input  logic          i_req,
   input  logic          d_req,
   input  logic [SW-1:0] dstreak,
   output logic          grant_i,
   output logic          grant_d
);
   always_comb begin
      grant_d = d_req & (!i_req | (dstreak < SW'(MAX_DSTREAK)));
      grant_i = i_req & !grant_d;
   end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters,
// one bus transaction at a time, with registered bus and response outputs.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int MAX_DSTREAK = 4,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              err,
   output logic              m_mreq,
   output logic              m_write,
   output logic [1:0]        m_size,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_wen,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ack_n
);
   localparam int SW = $clog2(MAX_DSTREAK + 1);
   state_t        state;
   logic [SW-1:0] dstreak;
   logic [7:0]    wcnt;
   logic          grant_i, grant_d, done;
   arb_grant_sel #(.MAX_DSTREAK(MAX_DSTREAK), .SW(SW)) u_sel (
      .i_req(i_req),
      .d_req(d_req),
      .dstreak(dstreak),
      .grant_i(grant_i),
      .grant_d(grant_d)
   );
   // an ack sampled in the same cycle as the timeout wins over the abort
   always_comb done = !m_ack_n || wcnt == 8'(TIMEOUT - 1);
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         dstreak <= '0;
         wcnt    <= '0;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         err     <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
         m_mreq  <= 1'b0;
         m_write <= 1'b0;
         m_wen   <= 1'b0;
         m_size  <= SZ_WORD;
         m_addr  <= '0;
         m_wdata <= '0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         err   <= 1'b0;
         if (!i_req) dstreak <= '0;
         case (state)
            IDLE: begin
               wcnt <= '0;
               if (grant_d) begin
                  state   <= D_BUSY;
                  m_mreq  <= 1'b1;
                  m_write <= d_we;
                  m_wen   <= d_we;
                  m_size  <= d_size;
                  m_addr  <= d_addr;
                  m_wdata <= d_wdata;
                  if (i_req) dstreak <= dstreak + SW'(1);
               end else if (grant_i) begin
                  state   <= I_BUSY;
                  m_mreq  <= 1'b1;
                  m_write <= 1'b0;
                  m_wen   <= 1'b0;
                  m_size  <= SZ_WORD;
                  m_addr  <= i_addr;
                  dstreak <= '0;
               end
            end
            I_BUSY, D_BUSY: begin
               wcnt <= wcnt + 8'd1;
               if (done) begin
                  state   <= RESP;
                  m_mreq  <= 1'b0;
                  m_write <= 1'b0;
                  m_wen   <= 1'b0;
                  err     <= m_ack_n;
                  if (state == I_BUSY) begin
                     i_ack   <= 1'b1;
                     i_rdata <= m_ack_n ? '0 : m_rdata;
                  end else begin
                     d_ack <= 1'b1;
                     if (m_ack_n) d_rdata <= '0;
                     else if (!m_write) d_rdata <= m_rdata;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven transactions plus hand sequences for
// contention, bus glitches, timeout and reset mid-access.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;
   logic        clk = 1'b0, rst = 1'b1;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic [1:0]  d_size = '0;
   logic        i_ack, d_ack, err, m_mreq, m_write, m_wen;
   logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
   logic [1:0]  m_size;
   logic [31:0] m_rdata = '0;
   logic        m_ack_n = 1'b1;
   int checks = 0, failures = 0;
   int lat = 1;
   bit stuck = 0, glitch = 0;
   logic [31:0] mem_data = '0;
   int bcnt = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .err(err),
      .m_mreq(m_mreq), .m_write(m_write), .m_size(m_size), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_wen(m_wen), .m_rdata(m_rdata), .m_ack_n(m_ack_n)
   );

   always #5 clk = ~clk;

   // memory: ack_n low for exactly the lat-th edge after m_mreq rises
   always @(negedge clk) begin
      if (m_mreq) begin
         bcnt++;
         m_ack_n = !(bcnt == lat && !stuck);
         m_rdata = mem_data;
      end else begin
         bcnt = 0;
         m_ack_n = !glitch;
      end
   end

   logic i_pend = 1'b0, d_pend = 1'b0;
   always @(posedge clk) begin
      if (rst) begin
         i_pend <= 1'b0;
         d_pend <= 1'b0;
      end else begin
         assert (!(i_pend && !i_req && !i_ack)) else $error("i_req dropped before i_ack");
         assert (!(d_pend && !d_req && !d_ack)) else $error("d_req dropped before d_ack");
         i_pend <= i_ack ? 1'b0 : (i_req ? 1'b1 : i_pend);
         d_pend <= d_ack ? 1'b0 : (d_req ? 1'b1 : d_pend);
      end
   end

   task automatic chk(input string t, input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s.%s actual=%h required=%h", t, n, act, exp);
      end
   endtask

   typedef struct {
      bit          is_d;
      bit          we;
      logic [1:0]  size;
      logic [31:0] addr, wdata, rdata;
      int          lat;
      bit          stuck;
      logic [31:0] x_wdata, x_rdata;
      bit          x_err;
   } vec_t;
   vec_t v[9];

   task automatic run_vec(input vec_t t, input string tag);
      int busy = 0, extra = 0, bad = 0, errs = 0;
      bit got = 0, seen = 0, ai = 0, ad = 0, e = 0;
      logic [31:0] a = '0, wd = '0, rd = '0;
      logic [1:0] sz = '0;
      logic wr = 1'b0, wen = 1'b0;
      lat = t.lat;
      stuck = t.stuck;
      mem_data = t.rdata;
      @(posedge clk); #1;
      if (t.is_d) begin
         d_req = 1; d_we = t.we; d_size = t.size; d_addr = t.addr; d_wdata = t.wdata;
      end else begin
         i_req = 1; i_addr = t.addr;
      end
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (m_mreq) begin
            if (!seen) begin
               seen = 1; a = m_addr; sz = m_size; wr = m_write; wen = m_wen; wd = m_wdata;
            end else if (m_addr !== a || m_wdata !== wd) bad++;
            busy++;
         end
         if (i_ack || d_ack) begin
            got = 1; ai = i_ack; ad = d_ack; e = err;
            rd = t.is_d ? d_rdata : i_rdata;
            i_req = 0; d_req = 0;
         end
      end
      chk(tag, "ack_seen", 32'(got), 32'd1);
      chk(tag, "m_addr", a, t.addr);
      chk(tag, "m_size", 32'(sz), t.is_d ? 32'(t.size) : 32'(SZ_WORD));
      chk(tag, "m_write", 32'(wr), 32'(t.is_d && t.we));
      chk(tag, "m_wen", 32'(wen), 32'(t.is_d && t.we));
      chk(tag, "m_wdata", wd, t.x_wdata);
      chk(tag, "busy_cycles", 32'(busy), t.stuck ? 32'd8 : 32'(t.lat));
      chk(tag, "bus_stable", 32'(bad), 32'd0);
      chk(tag, "i_ack", 32'(ai), 32'(!t.is_d));
      chk(tag, "d_ack", 32'(ad), 32'(t.is_d));
      chk(tag, "err", 32'(e), 32'(t.x_err));
      chk(tag, "rdata", rd, t.x_rdata);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (i_ack || d_ack || m_mreq) extra++;
         if (err) errs++;
      end
      chk(tag, "no_extra", 32'(extra), 32'd0);
      chk(tag, "err_pulse", 32'(errs), 32'd0);
      chk(tag, "rdata_hold", t.is_d ? d_rdata : i_rdata, t.x_rdata);
   endtask

   initial begin
      int n = 0, cnt = 0;
      bit prev = 0;
      bit got_d[10];
      bit exp_d[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      v[0] = '{0, 0, 2'b00, 32'h0000_0010, 32'h0, 32'h2002_0005, 1, 0, 32'h0, 32'h2002_0005, 0};
      v[1] = '{1, 1, 2'b10, 32'hF000_0000, 32'h41, 32'hFFFF_FFFF, 1, 0, 32'h41, 32'h0, 0};
      v[2] = '{1, 0, 2'b00, 32'h0800_0004, 32'h0, 32'hDEAD_BEEF, 3, 0, 32'h0, 32'hDEAD_BEEF, 0};
      v[3] = '{1, 1, 2'b01, 32'h0000_0100, 32'h1234, 32'hAAAA_AAAA, 2, 0, 32'h1234, 32'hDEAD_BEEF, 0};
      v[4] = '{0, 0, 2'b00, 32'h0000_0014, 32'h0, 32'h0000_0013, 2, 0, 32'h1234, 32'h0000_0013, 0};
      v[5] = '{1, 0, 2'b10, 32'h0000_0021, 32'h0, 32'h0000_0055, 1, 0, 32'h0, 32'h0000_0055, 0};
      v[6] = '{1, 0, 2'b00, 32'h0800_0008, 32'h0, 32'h0000_0077, 1, 1, 32'h0, 32'h0, 1};
      v[7] = '{0, 0, 2'b00, 32'h0000_0018, 32'h0, 32'h0000_0099, 1, 1, 32'h0, 32'h0, 1};
      v[8] = '{0, 0, 2'b00, 32'h0000_001C, 32'h0, 32'hCAFE_F00D, 1, 0, 32'h0, 32'hCAFE_F00D, 0};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", "m_mreq", 32'(m_mreq), 32'd0);
      chk("reset", "m_write_wen", {30'd0, m_write, m_wen}, 32'd0);
      chk("reset", "acks_err", {29'd0, i_ack, d_ack, err}, 32'd0);
      chk("reset", "m_size", 32'(m_size), 32'd0);
      chk("reset", "m_addr", m_addr, 32'd0);
      chk("reset", "m_wdata", m_wdata, 32'd0);
      chk("reset", "rdata", i_rdata | d_rdata, 32'd0);
      rst = 0;
      glitch = 1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (i_ack || d_ack || err || m_mreq) cnt++;
      end
      glitch = 0;
      chk("idle_glitch", "activity", 32'(cnt), 32'd0);
      for (int k = 0; k < 8; k++) run_vec(v[k], $sformatf("vec%0d", k));
      lat = 1; stuck = 0; mem_data = 32'h1;
      @(posedge clk); #1;
      i_addr = 32'h100; d_addr = 32'h200; d_we = 0; d_size = SZ_WORD;
      i_req = 1; d_req = 1;
      for (int c = 0; c < 200 && n < 10; c++) begin
         @(negedge clk);
         if (m_mreq && !prev) begin
            got_d[n] = (m_addr == 32'h200);
            n++;
         end
         prev = m_mreq;
      end
      for (int c = 0; c < 20 && i_req; c++) begin
         @(negedge clk);
         if (i_ack) i_req = 0;
      end
      for (int c = 0; c < 20 && d_req; c++) begin
         @(negedge clk);
         if (d_ack) d_req = 0;
      end
      chk("contend", "grants", 32'(n), 32'd10);
      for (int k = 0; k < 10; k++) chk("contend", $sformatf("grant%0d_is_d", k), 32'(got_d[k]), 32'(exp_d[k]));
      chk("contend", "reqs_released", {30'd0, i_req, d_req}, 32'd0);
      repeat (3) @(negedge clk);
      stuck = 1;
      @(posedge clk); #1;
      d_req = 1; d_we = 0; d_addr = 32'h300; d_size = SZ_WORD;
      repeat (3) @(negedge clk);
      chk("rst_mid", "busy_before", 32'(m_mreq), 32'd1);
      rst = 1; d_req = 0;
      @(posedge clk); #1;
      chk("rst_mid", "m_mreq", 32'(m_mreq), 32'd0);
      chk("rst_mid", "d_ack_err", {30'd0, d_ack, err}, 32'd0);
      chk("rst_mid", "m_addr", m_addr, 32'd0);
      chk("rst_mid", "state", 32'(dut.state), 32'(IDLE));
      @(negedge clk);
      rst = 0; stuck = 0; cnt = 0;
      repeat (3) begin
         @(negedge clk);
         if (d_ack || m_mreq) cnt++;
      end
      chk("rst_mid", "quiet_after", 32'(cnt), 32'd0);
      run_vec(v[8], "after_rst");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
